// File: rtl/stepper_phase_driver.sv
// Stepper phase driver: turns a gated step-pulse stream into the 4-phase
// unipolar coil pattern and tracks shaft position in half-steps modulo one
// revolution, pulsing revPulse on every wrap in either direction.
module stepper_phase_driver #(
    parameter int HALF_STEPS_PER_REV = 400,
    parameter int POS_W              = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stepIn,
    input  logic             dir,
    input  logic             fullStepMode,
    input  logic             enable,
    output logic [3:0]       coilOut,
    output logic [POS_W-1:0] position,
    output logic             revPulse,
    output logic             stepAck
);

    // Position math is one bit wider so pos+delta and pos+REV-delta never overflow.
    localparam logic [POS_W:0] REV = (POS_W+1)'(HALF_STEPS_PER_REV);

    logic             stepInD;
    logic [2:0]       phase;

    logic             stepEdge;
    logic             accept;
    logic [2:0]       phaseDelta;
    logic [POS_W:0]   delta;
    logic [POS_W:0]   posExt;
    logic [POS_W:0]   posSum;
    logic [2:0]       nextPhase;
    logic [POS_W:0]   nextPos;
    logic             wrap;

    // Coil pattern for each phase index; odd indices are the two-coil full steps.
    function automatic logic [3:0] phaseToCoil(input logic [2:0] p);
        logic [3:0] c;
        case (p)
            3'd0:    c = 4'b1000;
            3'd1:    c = 4'b1100;
            3'd2:    c = 4'b0100;
            3'd3:    c = 4'b0110;
            3'd4:    c = 4'b0010;
            3'd5:    c = 4'b0011;
            3'd6:    c = 4'b0001;
            3'd7:    c = 4'b1001;
            default: c = 4'b0000;
        endcase
        return c;
    endfunction

    // Next phase/position for an accepted step; an even phase in full-step mode
    // takes a single half-step onto the adjacent odd entry to realign.
    always_comb begin
        stepEdge   = stepIn & ~stepInD;
        accept     = stepEdge & enable;
        phaseDelta = (fullStepMode && phase[0]) ? 3'd2 : 3'd1;
        delta      = (POS_W+1)'(phaseDelta);
        posExt     = {1'b0, position};
        posSum     = posExt + delta;
        nextPhase  = phase;
        nextPos    = posExt;
        wrap       = 1'b0;
        if (accept) begin
            if (dir) begin
                nextPhase = phase + phaseDelta;
                if (posSum >= REV) begin
                    nextPos = posSum - REV;
                    wrap    = 1'b1;
                end else begin
                    nextPos = posSum;
                end
            end else begin
                nextPhase = phase - phaseDelta;
                if (posExt < delta) begin
                    nextPos = posExt + REV - delta;
                    wrap    = 1'b1;
                end else begin
                    nextPos = posExt - delta;
                end
            end
        end
    end

    // State and registered outputs; the edge detector keeps tracking while disabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            stepInD  <= 1'b0;
            phase    <= 3'd0;
            position <= '0;
            coilOut  <= 4'b0000;
            revPulse <= 1'b0;
            stepAck  <= 1'b0;
        end else begin
            stepInD  <= stepIn;
            phase    <= nextPhase;
            position <= nextPos[POS_W-1:0];
            coilOut  <= enable ? phaseToCoil(nextPhase) : 4'b0000;
            revPulse <= wrap;
            stepAck  <= accept;
        end
    end

endmodule

// File: tb/tb_stepper_phase_driver.sv
// Scoreboard bench for stepper_phase_driver: stimulus pushes the expected
// post-step state from a behavioural model, a monitor pops it on stepAck.
module tb_stepper_phase_driver;

    localparam int HSPR  = 400;
    localparam int POS_W = 9;

    localparam logic [3:0] COIL_TABLE [8] = '{4'b1000, 4'b1100, 4'b0100, 4'b0110,
                                               4'b0010, 4'b0011, 4'b0001, 4'b1001};

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             stepIn = 1'b0;
    logic             dir = 1'b1;
    logic             fullStepMode = 1'b0;
    logic             enable = 1'b0;
    logic [3:0]       coilOut;
    logic [POS_W-1:0] position;
    logic             revPulse;
    logic             stepAck;

    typedef struct {
        logic [3:0] coil;
        int         pos;
        bit         rev;
    } exp_t;

    exp_t expQ[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state: phase index and position as plain integers.
    int   mPhase = 0;
    int   mPos   = 0;

    stepper_phase_driver #(.HALF_STEPS_PER_REV(HSPR), .POS_W(POS_W)) dut (
        .clk(clk), .rst(rst), .stepIn(stepIn), .dir(dir),
        .fullStepMode(fullStepMode), .enable(enable),
        .coilOut(coilOut), .position(position),
        .revPulse(revPulse), .stepAck(stepAck)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        mPhase = 0;
        mPos   = 0;
    endtask

    task automatic modelStep(input bit d, input bit f);
        int   n;
        int   newPos;
        exp_t e;
        n      = (f && (mPhase % 2 == 1)) ? 2 : 1;
        mPhase = d ? (mPhase + n) % 8 : (mPhase + 8 - n) % 8;
        newPos = d ? mPos + n : mPos - n;
        e.rev  = (newPos >= HSPR) || (newPos < 0);
        mPos   = (newPos + HSPR) % HSPR;
        e.pos  = mPos;
        e.coil = COIL_TABLE[mPhase];
        expQ.push_back(e);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input bit d, input bit f, input bit en, input int hi, input int lo);
        dir          = d;
        fullStepMode = f;
        enable       = en;
        stepIn       = 1'b1;
        if (en) modelStep(d, f);
        repeat (hi) cyc();
        stepIn = 1'b0;
        repeat (lo) cyc();
    endtask

    task automatic doReset();
        rst    = 1'b1;
        stepIn = 1'b0;
        repeat (2) cyc();
        rst = 1'b0;
        modelReset();
    endtask

    task automatic checkState(input string name);
        @(negedge clk);
        chk({name, "_pos"}, int'(position), mPos);
        chk({name, "_coil"}, int'(coilOut), enable ? int'(COIL_TABLE[mPhase]) : 0);
        @(posedge clk);
        #1;
    endtask

    // Monitor: every accepted step must match the head of the scoreboard queue,
    // and revPulse must never appear without stepAck.
    always @(negedge clk) begin
        if (!rst) begin
            if (stepAck) begin
                checks++;
                if (expQ.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_ack: got stepAck=1 expected none at %0t", $time);
                end else begin
                    exp_t e;
                    e = expQ.pop_front();
                    chk("ack_coil", int'(coilOut), int'(e.coil));
                    chk("ack_pos", int'(position), e.pos);
                    chk("ack_rev", int'(revPulse), int'(e.rev));
                end
            end else begin
                chk("rev_without_ack", int'(revPulse), 0);
            end
        end
    end

    initial begin
        // Reset state
        repeat (2) cyc();
        @(negedge clk);
        chk("rst_coil", int'(coilOut), 0);
        chk("rst_pos", int'(position), 0);
        chk("rst_ack", int'(stepAck), 0);
        chk("rst_rev", int'(revPulse), 0);
        @(posedge clk);
        #1;
        doReset();

        // Half-step forward, 8 pulses, back to phase 0 at position 8
        for (int i = 0; i < 8; i++) pulse(1'b1, 1'b0, 1'b1, 1, 1);
        cyc();
        checkState("half_fwd8");
        chk("half_fwd8_abs", int'(position), 8);

        // Full-step forward from phase 0: 50 pulses end at 99
        doReset();
        for (int i = 0; i < 50; i++) pulse(1'b1, 1'b1, 1'b1, 1, 1);
        cyc();
        checkState("full_fwd50");
        chk("full_fwd50_abs", int'(position), 99);

        // Reverse wrap from 0, then walk to 398 and full-step forward across 0
        doReset();
        pulse(1'b0, 1'b0, 1'b1, 1, 2);
        checkState("rev_wrap");
        chk("rev_wrap_abs", int'(position), 399);
        pulse(1'b0, 1'b0, 1'b1, 1, 1);
        pulse(1'b1, 1'b1, 1'b1, 1, 1);
        pulse(1'b1, 1'b1, 1'b1, 1, 2);
        checkState("full_fwd_wrap");
        chk("full_fwd_wrap_abs", int'(position), 1);

        // Level held high for 20 cycles is one step
        doReset();
        pulse(1'b1, 1'b0, 1'b1, 20, 2);
        checkState("held_high");
        chk("held_high_abs", int'(position), 1);

        // Disabled: steps ignored, coils off
        for (int i = 0; i < 5; i++) pulse(1'b1, 1'b0, 1'b0, 1, 1);
        checkState("disabled");
        // Level held across enable rise is not a new step
        stepIn = 1'b1;
        repeat (3) cyc();
        enable = 1'b1;
        repeat (3) cyc();
        stepIn = 1'b0;
        cyc();
        checkState("reenable");

        // Randomized mix of direction, mode, enable and pulse widths
        for (int i = 0; i < 300; i++) begin
            pulse(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 7) != 0), $urandom_range(1, 3), $urandom_range(1, 3));
        end
        enable = 1'b1;
        cyc();
        checkState("random_end");

        // Reset mid-operation with stepIn high: cleared, then release counts as a step
        dir          = 1'b1;
        fullStepMode = 1'b0;
        enable       = 1'b1;
        stepIn       = 1'b1;
        rst          = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_coil", int'(coilOut), 0);
        chk("midrst_pos", int'(position), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        modelReset();
        modelStep(1'b1, 1'b0);
        repeat (3) cyc();
        stepIn = 1'b0;
        repeat (2) cyc();
        checkState("post_rst");

        chk("queue_drained", expQ.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/stepper_phase_driver.md
Name: stepper_phase_driver

Overview:
Consumes the gated step-pulse stream produced by the quarter-turn gate and other step sources, and drives the 4-phase coil pattern of the unipolar stepper motor.
Tracks motor shaft position in half-step units, modulo one revolution, and flags each revolution wrap.
Sits between the step gating logic and the coil driver pins.

Parameters:
HALF_STEPS_PER_REV, 400, half-steps per mechanical revolution (200 full steps).
POS_W, 9, width of the position counter; must satisfy 2^POS_W >= HALF_STEPS_PER_REV.

Ports:
clk  input  1  system clock
rst  input  1  reset, synchronous, active-high
stepIn  input  1  step request; the rising edge (stepIn high, previous-cycle sample low) is one step
dir  input  1  1 = forward (phase index +), 0 = reverse
fullStepMode  input  1  1 = full step (two coils on), 0 = half step
enable  input  1  0 = coils de-energised and steps ignored
coilOut  output  4  coil drive {A,B,C,D}, registered
position  output  POS_W  shaft position in half-steps, range 0..HALF_STEPS_PER_REV-1
revPulse  output  1  one-cycle pulse on position wrap, either direction
stepAck  output  1  one-cycle pulse for each accepted step

Behaviour:
- Reset (rst=1 at a clk edge):
  - phase=0, position=0, coilOut=4'b0000, revPulse=0, stepAck=0.
  - Edge-detect register cleared to 0, so stepIn held high through reset release counts as one step.
- Phase table, 3-bit index 0..7:
  - 1000, 1100, 0100, 0110, 0010, 0011, 0001, 1001.
- Edge detect:
  - stepInD is the registered copy of stepIn.
  - stepEdge = stepIn & ~stepInD.
  - stepIn held high for N cycles yields exactly one step.
- Accepted step: stepEdge & enable, evaluated at clk edge N. At that same edge:
  - Phase, position, coilOut, stepAck and revPulse all update.
  - Outputs are visible in cycle N+1 (1-cycle latency).
- Half-step mode:
  - phase <= phase±1, mod 8.
  - Delta = 1 half-step.
- Full-step mode:
  - If phase is odd: phase <= phase±2, delta 2.
  - If phase is even (left from half-step mode): phase <= phase±1 to the adjacent odd entry, delta 1.
  - After this alignment step, full mode only visits odd indices 1, 3, 5, 7.
- dir and fullStepMode are sampled only on the accepted-step cycle. Changes between steps have no effect on outputs.
- Position arithmetic:
  - Forward: position+delta. If the result is >= HALF_STEPS_PER_REV, subtract HALF_STEPS_PER_REV and assert revPulse.
  - Reverse: if position < delta, position+HALF_STEPS_PER_REV-delta and assert revPulse; otherwise position-delta.
  - Compute in POS_W+1 bits; no overflow permitted.
- coilOut:
  - enable=1: table[next phase] registered every cycle.
  - enable=0: 4'b0000 from the next cycle.
  - Re-asserting enable restores table[phase] the next cycle; phase and position are retained.
- enable=0:
  - Step edges are ignored: no stepAck, no phase or position change.
  - stepInD still tracks stepIn, so a level held across the enable rise is not a new step.
- revPulse and stepAck are high for exactly one cycle per accepted step. Back-to-back edges are at most one every 2 cycles because of the edge detector.
- rst asserted mid-operation overrides all other inputs in that cycle.

Test Plan:
- Reset, then enable=1, dir=1, fullStepMode=0, 8 single-cycle stepIn pulses:
  - coilOut steps 1100, 0100, 0110, 0010, 0011, 0001, 1001, 1000.
  - position reaches 8.
  - stepAck pulses 8 times, each 1 cycle after its edge.
- From reset (phase 0), fullStepMode=1, dir=1, 50 pulses:
  - First pulse gives coilOut=1100, position=1.
  - Then 1-step-per-pulse odd phases; final position=99.
  - No revPulse.
- From position 0, phase 0, dir=0, fullStepMode=0, 1 pulse:
  - position=399, coilOut=1001, revPulse high for exactly 1 cycle.
- stepIn held high 20 cycles, then low:
  - Exactly 1 stepAck, position=1.
- enable=0 with 5 stepIn pulses:
  - coilOut=0000, position unchanged, no stepAck.
- Then enable=1:
  - coilOut=table[phase] the next cycle.
- Forward full steps from position 398 at phase 7:
  - 1 pulse gives position 0, phase 1 (coilOut 1100), revPulse=1.
- rst asserted during the sequence:
  - Next cycle coilOut=0000, position=0.
